// File: rtl/smoother_pkg.sv
// rtl/smoother_pkg.sv - shared state encoding, defaults and sizing helpers for spectrum_smoother
package smoother_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam int DEF_DW        = 16;
   localparam int DEF_FRAME_LEN = 1024;

   // Running sum of 2^log2_win samples of dw bits can never overflow this width
   function automatic int sum_width(input int dw, input int log2_win);
      return dw + log2_win;
   endfunction

endpackage

// File: rtl/smoother_delay_line.sv
// rtl/smoother_delay_line.sv - circular W-entry sample history; oldest entry sits at the write pointer
module smoother_delay_line
   import smoother_pkg::*;
#(
   parameter int DW         = DEF_DW,
   parameter int LOG2_DEPTH = 3
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          we,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] oldest
);

   localparam int DEPTH = 1 << LOG2_DEPTH;

   logic [DW-1:0]         mem [DEPTH];
   logic [LOG2_DEPTH-1:0] wptr;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wptr <= '0;
      end else if (we) begin
         mem[wptr] <= wdata;
         wptr      <= wptr + 1'b1;
      end
   end

   assign oldest = mem[wptr];

endmodule

// File: rtl/spectrum_smoother.sv
// rtl/spectrum_smoother.sv - framed causal moving-average smoother; SMOOTHER_LEN_CHECK_EN adds frame length checking
module spectrum_smoother
   import smoother_pkg::*;
#(
   parameter int DW        = DEF_DW,
   parameter int LOG2_WIN  = 3,
   parameter int FRAME_LEN = DEF_FRAME_LEN
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          ce,
   input  logic [DW-1:0] tdata_s,
   input  logic          tuser_s,
   input  logic          tlast_s,
   input  logic          tvalid_s,
   output logic          tready_s,
   output logic [DW-1:0] tdata_m,
   output logic          tuser_m,
   output logic          tlast_m,
   output logic          tvalid_m,
   input  logic          tready_m,
   output logic          frame_err
);

   localparam int SW = sum_width(DW, LOG2_WIN);
   localparam int W  = 1 << LOG2_WIN;
   localparam int FW = LOG2_WIN + 1;

   state_t               state;
   logic signed [SW-1:0] sum;
   logic signed [SW-1:0] sum_nxt;
   logic signed [SW-1:0] x_ext;
   logic signed [SW-1:0] old_ext;
   logic [FW-1:0]        fill;
   logic [DW-1:0]        oldest;
   logic [DW-1:0]        y;
   logic                 accept;
   logic                 start;
   logic                 process;
   logic                 full;
   logic                 force_last;

   assign tready_s = ce && (!tvalid_m || tready_m);
   assign accept   = tvalid_s && tready_s;
   assign start    = accept && tuser_s;
   assign process  = start || (accept && (state == ST_RUN));
   assign full     = (fill == FW'(W));

   assign x_ext   = {{LOG2_WIN{tdata_s[DW-1]}}, tdata_s};
   assign old_ext = {{LOG2_WIN{oldest[DW-1]}}, oldest};

   // A frame start discards history, so only fill (not the delay line contents) needs clearing
   assign sum_nxt = start ? x_ext : (sum + x_ext - (full ? old_ext : '0));
   assign y       = DW'(sum_nxt >>> LOG2_WIN);

   smoother_delay_line #(
      .DW         (DW),
      .LOG2_DEPTH (LOG2_WIN)
   ) u_delay_line (
      .clk     (clk),
      .reset_n (reset_n),
      .we      (process),
      .wdata   (tdata_s),
      .oldest  (oldest)
   );

`ifdef SMOOTHER_LEN_CHECK_EN
   localparam int IW = 10;

   logic [IW-1:0] index;
   logic [IW-1:0] idx_cur;
   logic          len_err;

   assign idx_cur    = start ? '0 : index;
   assign force_last = process && !tlast_s && (idx_cur == IW'(FRAME_LEN - 1));
   assign len_err    = process && ((tlast_s && (idx_cur != IW'(FRAME_LEN - 1))) || force_last);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         index     <= '0;
         frame_err <= 1'b0;
      end else begin
         frame_err <= len_err;
         if (process) index <= idx_cur + 1'b1;
      end
   end
`else
   logic unused_frame_len;

   assign unused_frame_len = ^FRAME_LEN;
   assign force_last       = 1'b0;
   assign frame_err        = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= ST_IDLE;
         sum      <= '0;
         fill     <= '0;
         tvalid_m <= 1'b0;
         tdata_m  <= '0;
         tuser_m  <= 1'b0;
         tlast_m  <= 1'b0;
      end else if (ce) begin
         if (process) begin
            sum      <= sum_nxt;
            fill     <= start ? FW'(1) : (full ? fill : fill + 1'b1);
            state    <= (tlast_s || force_last) ? ST_IDLE : ST_RUN;
            tdata_m  <= y;
            tuser_m  <= tuser_s;
            tlast_m  <= tlast_s || force_last;
            tvalid_m <= 1'b1;
         end else if (tready_m) begin
            tvalid_m <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_spectrum_smoother.sv
// tb/tb_spectrum_smoother.sv - directed self-checking bench for spectrum_smoother (SMOOTHER_LEN_CHECK_EN aware)
module tb_spectrum_smoother;

   localparam int DW        = 16;
   localparam int LOG2_WIN  = 3;
   localparam int W         = 8;
   localparam int FRAME_LEN = 1024;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          ce;
   logic [DW-1:0] tdata_s;
   logic          tuser_s;
   logic          tlast_s;
   logic          tvalid_s;
   logic          tready_s;
   logic [DW-1:0] tdata_m;
   logic          tuser_m;
   logic          tlast_m;
   logic          tvalid_m;
   logic          tready_m;
   logic          frame_err;

   int n_tests = 0;
   int n_fail  = 0;

   int exp_d[$];
   bit exp_u[$];
   bit exp_l[$];
   int obs_d[$];
   bit obs_u[$];
   bit obs_l[$];
   int hist[$];
   bit in_frame   = 1'b0;
   int idx        = 0;
   int err_pulses = 0;

   always #5 clk = ~clk;

   spectrum_smoother #(
      .DW        (DW),
      .LOG2_WIN  (LOG2_WIN),
      .FRAME_LEN (FRAME_LEN)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .ce        (ce),
      .tdata_s   (tdata_s),
      .tuser_s   (tuser_s),
      .tlast_s   (tlast_s),
      .tvalid_s  (tvalid_s),
      .tready_s  (tready_s),
      .tdata_m   (tdata_m),
      .tuser_m   (tuser_m),
      .tlast_m   (tlast_m),
      .tvalid_m  (tvalid_m),
      .tready_m  (tready_m),
      .frame_err (frame_err)
   );

   task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference: direct sum of the last W in-frame inputs, floored by the arithmetic shift
   task automatic model_push(input int x, input bit u, input bit l);
      int s;
      bit ll;
      if (u) begin
         hist.delete();
         in_frame = 1'b1;
         idx      = 0;
      end
      if (!in_frame) return;
      hist.push_back(x);
      if (hist.size() > W) void'(hist.pop_front());
      s = 0;
      foreach (hist[i]) s += hist[i];
      ll = l;
`ifdef SMOOTHER_LEN_CHECK_EN
      if (!l && idx == FRAME_LEN - 1) ll = 1'b1;
`endif
      exp_d.push_back(s >>> LOG2_WIN);
      exp_u.push_back(u);
      exp_l.push_back(ll);
      idx++;
      if (ll) in_frame = 1'b0;
   endtask

   always @(negedge clk) begin
      if (reset_n && frame_err) err_pulses++;
      if (reset_n && ce && tvalid_m && tready_m) begin
         obs_d.push_back(int'($signed(tdata_m)));
         obs_u.push_back(tuser_m);
         obs_l.push_back(tlast_m);
         if (exp_d.size() == 0) begin
            check("unexpected_output", 1, 0);
         end else begin
            check("out_data", $signed(tdata_m), exp_d.pop_front());
            check("out_user", tuser_m, exp_u.pop_front());
            check("out_last", tlast_m, exp_l.pop_front());
         end
      end
   end

   task automatic send(input int x, input bit u, input bit l);
      int t;
      t = 0;
      @(posedge clk);
      #1;
      tdata_s  = x[DW-1:0];
      tuser_s  = u;
      tlast_s  = l;
      tvalid_s = 1'b1;
      @(negedge clk);
      while (!tready_s && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!tready_s) begin
         check("send_timeout", 0, 1);
         tvalid_s = 1'b0;
         return;
      end
      model_push(x, u, l);
   endtask

   task automatic end_tx();
      @(posedge clk);
      #1;
      tvalid_s = 1'b0;
      tuser_s  = 1'b0;
      tlast_s  = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (exp_d.size() != 0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      check("drain_empty", exp_d.size(), 0);
      @(negedge clk);
   endtask

   task automatic clear_obs();
      obs_d.delete();
      obs_u.delete();
      obs_l.delete();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      longint t0;
      longint t1;
      logic [DW-1:0] held;

      reset_n  = 1'b0;
      ce       = 1'b1;
      tdata_s  = '0;
      tuser_s  = 1'b0;
      tlast_s  = 1'b0;
      tvalid_s = 1'b0;
      tready_m = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_tvalid", tvalid_m, 0);
      check("rst_tdata", tdata_m, 0);
      check("rst_tuser", tuser_m, 0);
      check("rst_tlast", tlast_m, 0);
      check("rst_frame_err", frame_err, 0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(negedge clk);
      check("rst_tready_s", tready_s, 1);

      // Constant 800 over a full frame at full throughput
      clear_obs();
      t0 = 0;
      t1 = 0;
      for (int i = 0; i < FRAME_LEN; i++) begin
         send(800, i == 0, i == FRAME_LEN - 1);
         if (i == 0) t0 = $time;
         if (i == FRAME_LEN - 1) t1 = $time;
      end
      end_tx();
      drain();
      check("c800_count", obs_d.size(), FRAME_LEN);
      check("c800_rate", 32'((t1 - t0) / 10), FRAME_LEN - 1);
      check("c800_out0", obs_d[0], 100);
      check("c800_out1", obs_d[1], 200);
      check("c800_out6", obs_d[6], 700);
      check("c800_out7", obs_d[7], 800);
      check("c800_out1023", obs_d[1023], 800);
      check("c800_user0", obs_u[0], 1);
      check("c800_last1022", obs_l[1022], 0);
      check("c800_last1023", obs_l[1023], 1);

      // One-sample frame of -1
      clear_obs();
      send(-1, 1'b1, 1'b1);
      end_tx();
      drain();
      check("single_count", obs_d.size(), 1);
      check("single_data", obs_d[0], -1);
      check("single_user", obs_u[0], 1);
      check("single_last", obs_l[0], 1);

      // Out-of-frame beats are dropped, then a 4-beat ramp-up frame
      clear_obs();
      send(5, 1'b0, 1'b0);
      send(6, 1'b0, 1'b0);
      send(7, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) send(8, i == 0, i == 3);
      end_tx();
      drain();
      check("drop_count", obs_d.size(), 4);
      for (int i = 0; i < 4; i++) check("drop_ramp", obs_d[i], i + 1);

      // Restart mid-frame clears history
      clear_obs();
      for (int i = 0; i < 10; i++) send(40, i == 0, 1'b0);
      for (int i = 0; i < 4; i++) send(80, i == 0, i == 3);
      end_tx();
      drain();
      check("restart_count", obs_d.size(), 14);
      check("restart_prev", obs_d[9], 40);
      check("restart_prev_last", obs_l[9], 0);
      check("restart_data", obs_d[10], 10);
      check("restart_user", obs_u[10], 1);

      // Backpressure: five stalled cycles mid-frame
      clear_obs();
      fork
         begin
            for (int i = 0; i < 20; i++) send(i * 37 - 300, i == 0, i == 19);
         end
         begin
            repeat (6) @(posedge clk);
            #1;
            tready_m = 1'b0;
            @(negedge clk);
            held = tdata_m;
            check("stall_valid", tvalid_m, 1);
            check("stall_ready_s", tready_s, 0);
            repeat (4) begin
               @(negedge clk);
               check("stall_hold_data", tdata_m, held);
               check("stall_hold_valid", tvalid_m, 1);
               check("stall_ready_s", tready_s, 0);
            end
            @(posedge clk);
            #1;
            tready_m = 1'b1;
         end
      join
      end_tx();
      drain();
      check("stall_count", obs_d.size(), 20);

      // Clock enable low blocks acceptance
      clear_obs();
      fork
         begin
            @(posedge clk);
            #1;
            ce = 1'b0;
            repeat (3) begin
               @(negedge clk);
               check("ce_ready_s", tready_s, 0);
               check("ce_tvalid_m", tvalid_m, 0);
            end
            @(posedge clk);
            #1;
            ce = 1'b1;
         end
         begin
            send(123, 1'b1, 1'b1);
         end
      join
      end_tx();
      drain();
      check("ce_count", obs_d.size(), 1);
      check("ce_data", obs_d[0], 15);

`ifdef SMOOTHER_LEN_CHECK_EN
      // Early tlast at index 500
      clear_obs();
      err_pulses = 0;
      for (int i = 0; i < 501; i++) send(16, i == 0, i == 500);
      end_tx();
      drain();
      check("short_count", obs_d.size(), 501);
      check("short_err", err_pulses, 1);

      // Missing tlast: forced at output 1023, remainder dropped
      clear_obs();
      err_pulses = 0;
      for (int i = 0; i < FRAME_LEN + 6; i++) send(8, i == 0, 1'b0);
      end_tx();
      drain();
      check("long_count", obs_d.size(), FRAME_LEN);
      check("long_forced_last", obs_l[FRAME_LEN - 1], 1);
      check("long_err", err_pulses, 1);
      clear_obs();
      send(64, 1'b1, 1'b1);
      end_tx();
      drain();
      check("long_recover", obs_d.size(), 1);
      check("long_recover_data", obs_d[0], 8);
`else
      check("no_frame_err", err_pulses, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
